// File: rtl/img_metadata_header_fifo_pkg.sv
// Shared definitions for the image metadata header FIFO: record field layout,
// FSM state type and the record packing helper.
package img_meta_pkg;

    localparam int META_W    = 48;
    localparam int COMP_MSB  = 47;
    localparam int COMP_LSB  = 46;
    localparam int RGB_BIT   = 45;
    localparam int CAM_BIT   = 44;
    localparam int TS_MSB    = 43;
    localparam int TS_LSB    = 16;
    localparam int TRIG_MSB  = 15;
    localparam int TRIG_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } hdr_state_t;

    function automatic logic [META_W-1:0] pack_meta(
        input logic [1:0]  compression,
        input logic        rgb,
        input logic        cam_id,
        input logic [27:0] timestamp,
        input logic [15:0] trigger_index
    );
        logic [META_W-1:0] rec;
        rec                     = '0;
        rec[COMP_MSB:COMP_LSB]  = compression;
        rec[RGB_BIT]            = rgb;
        rec[CAM_BIT]            = cam_id;
        rec[TS_MSB:TS_LSB]      = timestamp;
        rec[TRIG_MSB:TRIG_LSB]  = trigger_index;
        return rec;
    endfunction

endpackage

// File: rtl/img_metadata_header_fifo_if.sv
// Metadata push side (from the MCB) and slice stream side (to the JPG block)
// of the header FIFO. The FIFO itself sits on the slave modport.
interface img_metadata_header_fifo_if #(
    parameter int CHUNK_W = 12
);
    logic [1:0]         compression;
    logic               RGB;
    logic               cam_id;
    logic [27:0]        timestamp;
    logic [15:0]        trigger_index;
    logic               meta_valid;
    logic               meta_ready;
    logic [CHUNK_W-1:0] chunk_out;
    logic               chunk_valid;
    logic               chunk_ready;
    logic               chunk_last;

    modport master (
        output compression, RGB, cam_id, timestamp, trigger_index, meta_valid, chunk_ready,
        input  meta_ready, chunk_out, chunk_valid, chunk_last
    );

    modport slave (
        input  compression, RGB, cam_id, timestamp, trigger_index, meta_valid, chunk_ready,
        output meta_ready, chunk_out, chunk_valid, chunk_last
    );
endinterface

// File: rtl/img_metadata_header_fifo_sync_fifo.sv
// Single-clock record FIFO with a registered occupancy count; full/empty are
// decoded from that count so there is no read-to-write bypass.
module meta_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     sysClk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge sysClk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/img_metadata_header_fifo.sv
// Queues metadata records and, per end-of-image request, streams the oldest one
// MSB-first as CHUNK_W slices.
//   state | meaning
//   IDLE  | waiting for a pending flush request and a stored record
//   LOAD  | copy head record into the shift register, present slice 0
//   SEND  | present slices; pop record after the last slice handshake
module img_metadata_header_fifo
    import img_meta_pkg::*;
#(
    parameter int META_W  = 48,
    parameter int CHUNK_W = 12,
    parameter int DEPTH   = 4
) (
    input  logic                     sysClk,
    input  logic                     rst_n,
    input  logic                     all_pixels_in,
    img_metadata_header_fifo_if.slave hdr,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     orphan_eoi
);
    localparam int NCHUNK = META_W / CHUNK_W;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (META_W != img_meta_pkg::META_W) begin : g_bad_meta_w
        $error("META_W must match the packed record width");
    end
    if (META_W % CHUNK_W != 0) begin : g_bad_chunk_w
        $error("META_W must be a multiple of CHUNK_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    logic [META_W-1:0] rec_in;
    logic [META_W-1:0] head_rec;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [1:0]        sync_q;
    logic              sync_prev;
    logic              eoi_edge;
    logic              eoi_accept;
    logic [CW-1:0]     pending;
    hdr_state_t        state;
    logic [META_W-1:0] shift_q;
    logic [META_W-1:0] shift_nxt;
    logic [IW-1:0]     idx;

    assign rec_in = pack_meta(hdr.compression, hdr.RGB, hdr.cam_id, hdr.timestamp, hdr.trigger_index);

    meta_sync_fifo #(.WIDTH(META_W), .DEPTH(DEPTH)) u_fifo (
        .sysClk  (sysClk),
        .rst_n   (rst_n),
        .wr_en   (hdr.meta_valid),
        .wr_data (rec_in),
        .rd_en   (pop),
        .rd_data (head_rec),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign hdr.meta_ready = !fifo_full;
    assign pop            = (state == ST_SEND) && hdr.chunk_valid && hdr.chunk_ready && hdr.chunk_last;
    assign eoi_edge       = sync_q[1] && !sync_prev;
    assign eoi_accept     = eoi_edge && !(fifo_empty && pending == '0);
    assign shift_nxt      = shift_q << CHUNK_W;

    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], all_pixels_in};
            sync_prev <= sync_q[1];
        end
    end

    // A request arriving with nothing stored and nothing owed is dropped, not banked.
    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (eoi_accept && !pop) begin
            if (pending != CW'(DEPTH)) pending <= pending + 1'b1;
        end else if (pop && !eoi_accept) begin
            pending <= pending - 1'b1;
        end
    end

    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            orphan_eoi <= 1'b0;
        end else begin
            if (hdr.meta_valid && !hdr.meta_ready) overflow <= 1'b1;
            if (eoi_edge && fifo_empty && pending == '0) orphan_eoi <= 1'b1;
        end
    end

    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            shift_q         <= '0;
            idx             <= '0;
            hdr.chunk_out   <= '0;
            hdr.chunk_valid <= 1'b0;
            hdr.chunk_last  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pending != '0 && !fifo_empty) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift_q         <= head_rec;
                    idx             <= '0;
                    hdr.chunk_out   <= head_rec[META_W-1 -: CHUNK_W];
                    hdr.chunk_valid <= 1'b1;
                    hdr.chunk_last  <= (NCHUNK == 1);
                    state           <= ST_SEND;
                end
                ST_SEND: begin
                    if (hdr.chunk_valid && hdr.chunk_ready) begin
                        if (hdr.chunk_last) begin
                            hdr.chunk_out   <= '0;
                            hdr.chunk_valid <= 1'b0;
                            hdr.chunk_last  <= 1'b0;
                            state           <= ST_IDLE;
                        end else begin
                            shift_q        <= shift_nxt;
                            idx            <= idx + 1'b1;
                            hdr.chunk_out  <= shift_nxt[META_W-1 -: CHUNK_W];
                            hdr.chunk_last <= (idx == IW'(NCHUNK - 2));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_img_metadata_header_fifo.sv
// Directed bench for the metadata header FIFO: slicing order, full/overflow,
// stalled stream, orphan end-of-image and reset mid-record.
module tb_img_metadata_header_fifo;

    logic sysClk;
    logic rst_n;
    logic all_pixels_in;
    logic [2:0] fifo_count;
    logic overflow;
    logic orphan_eoi;

    int n_chk;
    int n_pass;
    int cyc;
    logic seen;

    img_metadata_header_fifo_if #(.CHUNK_W(12)) hdr_if ();

    img_metadata_header_fifo #(.META_W(48), .CHUNK_W(12), .DEPTH(4)) u_dut (
        .sysClk        (sysClk),
        .rst_n         (rst_n),
        .all_pixels_in (all_pixels_in),
        .hdr           (hdr_if),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .orphan_eoi    (orphan_eoi)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    localparam logic [47:0] REC_T1 = 48'hA0AB_CDEF_1234;
    localparam logic [47:0] REC_0  = 48'h1234_5678_9ABC;
    localparam logic [47:0] REC_1  = 48'hFEDC_BA98_7654;
    localparam logic [47:0] REC_2  = 48'h0F0F_0F0F_0F0F;
    localparam logic [47:0] REC_3  = 48'hC3A5_5A3C_9669;
    localparam logic [47:0] REC_X  = 48'hBAD0_BAD0_BAD0;
    localparam logic [47:0] REC_4  = 48'h8000_0000_0001;
    localparam logic [47:0] REC_5  = 48'h7FFF_FFFF_FFFE;
    localparam logic [47:0] REC_6  = 48'hDEAD_BEEF_CAFE;
    localparam logic [47:0] REC_7  = 48'h0123_4567_89AB;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic push(input logic [47:0] rec);
        hdr_if.compression   = rec[47:46];
        hdr_if.RGB           = rec[45];
        hdr_if.cam_id        = rec[44];
        hdr_if.timestamp     = rec[43:16];
        hdr_if.trigger_index = rec[15:0];
        hdr_if.meta_valid    = 1'b1;
        tick();
        hdr_if.meta_valid    = 1'b0;
    endtask

    task automatic eoi_pulse();
        all_pixels_in = 1'b1;
        repeat (3) tick();
        all_pixels_in = 1'b0;
        repeat (3) tick();
    endtask

    // stall_mod = 0: always ready; otherwise ready one cycle out of stall_mod.
    task automatic recv_record(input string tag, input logic [47:0] rec, input int stall_mod);
        int idx;
        int c;
        logic [11:0] exp_s;
        idx = 0;
        c   = 0;
        while (idx < 4 && c < 300) begin
            hdr_if.chunk_ready = (stall_mod == 0) || (c % stall_mod == 0);
            if (hdr_if.chunk_valid) begin
                exp_s = 12'(rec >> (36 - 12 * idx));
                chk({tag, "_data"}, 64'(hdr_if.chunk_out), 64'(exp_s));
                if (hdr_if.chunk_ready) begin
                    chk({tag, "_last"}, 64'(hdr_if.chunk_last), 64'(idx == 3));
                    idx++;
                end
            end
            tick();
            c++;
        end
        chk({tag, "_done"}, 64'(idx), 64'd4);
        chk({tag, "_gap"}, 64'(hdr_if.chunk_valid), 64'd0);
        hdr_if.chunk_ready = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        all_pixels_in = 1'b0;
        hdr_if.compression = '0;
        hdr_if.RGB = 1'b0;
        hdr_if.cam_id = 1'b0;
        hdr_if.timestamp = '0;
        hdr_if.trigger_index = '0;
        hdr_if.meta_valid = 1'b0;
        hdr_if.chunk_ready = 1'b0;
        repeat (3) tick();
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ready", 64'(hdr_if.meta_ready), 64'd1);
        chk("rst_valid", 64'(hdr_if.chunk_valid), 64'd0);
        chk("rst_out", 64'(hdr_if.chunk_out), 64'd0);
        chk("rst_last", 64'(hdr_if.chunk_last), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_orphan", 64'(orphan_eoi), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: single record, latency and slice order
        hdr_if.compression   = 2'b10;
        hdr_if.RGB           = 1'b1;
        hdr_if.cam_id        = 1'b0;
        hdr_if.timestamp     = 28'h0ABCDEF;
        hdr_if.trigger_index = 16'h1234;
        hdr_if.meta_valid    = 1'b1;
        tick();
        hdr_if.meta_valid    = 1'b0;
        chk("t1_count", 64'(fifo_count), 64'd1);
        all_pixels_in = 1'b1;
        repeat (4) @(posedge sysClk);
        #1;
        chk("t1_lat_early", 64'(hdr_if.chunk_valid), 64'd0);
        tick();
        chk("t1_lat", 64'(hdr_if.chunk_valid), 64'd1);
        all_pixels_in = 1'b0;
        recv_record("t1", REC_T1, 0);
        chk("t1_count_end", 64'(fifo_count), 64'd0);

        // 2: fill, overflow, then four flushes in order
        push(REC_0);
        push(REC_1);
        push(REC_2);
        push(REC_3);
        chk("t2_count_full", 64'(fifo_count), 64'd4);
        chk("t2_ready_full", 64'(hdr_if.meta_ready), 64'd0);
        chk("t2_ovf_before", 64'(overflow), 64'd0);
        push(REC_X);
        chk("t2_ovf", 64'(overflow), 64'd1);
        chk("t2_count_ovf", 64'(fifo_count), 64'd4);
        repeat (4) eoi_pulse();
        recv_record("t2_r0", REC_0, 0);
        recv_record("t2_r1", REC_1, 0);
        recv_record("t2_r2", REC_2, 0);
        recv_record("t2_r3", REC_3, 0);
        chk("t2_count_end", 64'(fifo_count), 64'd0);
        chk("t2_ready_end", 64'(hdr_if.meta_ready), 64'd1);
        chk("t2_ovf_sticky", 64'(overflow), 64'd1);

        // 3: stalled stream
        push(REC_4);
        eoi_pulse();
        recv_record("t3", REC_4, 3);

        // 4: orphan end-of-image, later push must not emit
        chk("t4_orphan_before", 64'(orphan_eoi), 64'd0);
        eoi_pulse();
        chk("t4_orphan", 64'(orphan_eoi), 64'd1);
        chk("t4_valid", 64'(hdr_if.chunk_valid), 64'd0);
        push(REC_5);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (hdr_if.chunk_valid) seen = 1'b1;
        end
        chk("t4_no_emit", 64'(seen), 64'd0);
        chk("t4_count", 64'(fifo_count), 64'd1);
        eoi_pulse();
        recv_record("t4", REC_5, 0);

        // 5: reset during the second slice
        push(REC_6);
        eoi_pulse();
        cyc = 0;
        while (!hdr_if.chunk_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("t5_valid", 64'(hdr_if.chunk_valid), 64'd1);
        chk("t5_slice0", 64'(hdr_if.chunk_out), 64'hDEA);
        hdr_if.chunk_ready = 1'b1;
        tick();
        hdr_if.chunk_ready = 1'b0;
        chk("t5_slice1", 64'(hdr_if.chunk_out), 64'hDBE);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(hdr_if.chunk_valid), 64'd0);
        chk("t5_rst_out", 64'(hdr_if.chunk_out), 64'd0);
        chk("t5_rst_last", 64'(hdr_if.chunk_last), 64'd0);
        chk("t5_rst_count", 64'(fifo_count), 64'd0);
        chk("t5_rst_ovf", 64'(overflow), 64'd0);
        chk("t5_rst_orphan", 64'(orphan_eoi), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        push(REC_7);
        eoi_pulse();
        recv_record("t5", REC_7, 0);
        chk("t5_orphan_after", 64'(orphan_eoi), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
